// File: rtl/bpm_swap_deswap_n.sv
// Multi-pair BPM crossbar swap driver, delayed deswap and per-path gain compensation with saturation.
// Optional external phase sync input enabled by defining BPM_SWAP_EXT_SYNC_EN.
module bpm_swap_deswap_n #(
  parameter int unsigned G_NUM_PAIRS  = 2,
  parameter int unsigned G_DATA_WIDTH = 16,
  parameter int unsigned G_GAIN_WIDTH = 16,
  parameter int unsigned G_GAIN_FRAC  = 14,
  parameter int unsigned G_DIV_WIDTH  = 16,
  parameter int unsigned G_DLY_WIDTH  = 16
) (
  input  logic                                     clk_sys_i,
  input  logic                                     rst_n_i,
  input  logic [2*G_NUM_PAIRS*G_DATA_WIDTH-1:0]    adc_data_i,
  input  logic                                     adc_valid_i,
  input  logic [2*G_NUM_PAIRS-1:0]                 mode_i,
  input  logic [G_DIV_WIDTH-1:0]                   swap_div_f_i,
  input  logic [G_DLY_WIDTH-1:0]                   deswap_dly_i,
  input  logic [2*G_NUM_PAIRS*G_GAIN_WIDTH-1:0]    gain_dir_i,
  input  logic [2*G_NUM_PAIRS*G_GAIN_WIDTH-1:0]    gain_inv_i,
`ifdef BPM_SWAP_EXT_SYNC_EN
  input  logic                                     sync_trig_i,
`endif
  output logic [2*G_NUM_PAIRS*G_DATA_WIDTH-1:0]    data_o,
  output logic                                     data_valid_o,
  output logic [2*G_NUM_PAIRS-1:0]                 ctrl_o,
  output logic                                     swap_sync_o
);

  localparam int unsigned NCH = 2 * G_NUM_PAIRS;
  localparam int unsigned DW  = G_DATA_WIDTH;
  localparam int unsigned GW  = G_GAIN_WIDTH;
  localparam int unsigned PW  = G_DATA_WIDTH + G_GAIN_WIDTH + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [G_DIV_WIDTH-1:0] r_cnt;
  logic [G_DLY_WIDTH-1:0] r_dly_cnt;
  logic                   r_swap_state;
  logic                   r_deswap_state;
  logic                   r_swap_sync;
  logic [NCH-1:0]         r_ctrl;
  logic                   w_toggle;
  logic                   w_force;

  logic                   r_s1_valid;
  logic signed [DW-1:0]   r_s1_data [NCH];
  logic [GW-1:0]          r_s1_gain [NCH];
  logic                   r_s1_off  [NCH];
  logic                   r_valid;
  logic [NCH*DW-1:0]      r_data;

  logic [1:0]             w_ctrl    [G_NUM_PAIRS];
  logic                   w_cross   [G_NUM_PAIRS];
  logic signed [DW-1:0]   w_s1_data [NCH];
  logic [GW-1:0]          w_s1_gain [NCH];
  logic                   w_s1_off  [NCH];
  logic signed [DW-1:0]   w_res     [NCH];
  logic signed [PW-1:0]   w_a, w_b, w_p, w_sh;

`ifdef BPM_SWAP_EXT_SYNC_EN
  assign w_force = sync_trig_i;
`else
  assign w_force = 1'b0;
`endif

  assign w_toggle = (swap_div_f_i != '0) && (r_cnt >= swap_div_f_i);

  // Swap frequency divider; external sync overrides a coincident toggle.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      r_cnt        <= '0;
      r_swap_state <= 1'b0;
      r_swap_sync  <= 1'b0;
    end else if (w_force) begin
      r_cnt        <= '0;
      r_swap_state <= 1'b0;
      r_swap_sync  <= 1'b0;
    end else if (swap_div_f_i == '0) begin
      r_cnt        <= '0;
      r_swap_sync  <= 1'b0;
    end else if (w_toggle) begin
      r_cnt        <= '0;
      r_swap_state <= ~r_swap_state;
      r_swap_sync  <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + G_DIV_WIDTH'(1);
      r_swap_sync  <= 1'b0;
    end
  end

  // Deswap follows swap_state once the settling countdown has expired.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i || w_force) begin
      r_dly_cnt      <= '0;
      r_deswap_state <= 1'b0;
    end else begin
      if (w_toggle) begin
        r_dly_cnt <= deswap_dly_i;
      end else if (r_dly_cnt != '0) begin
        r_dly_cnt <= r_dly_cnt - G_DLY_WIDTH'(1);
      end
      if (r_dly_cnt == '0) begin
        r_deswap_state <= r_swap_state;
      end
    end
  end

  // Per-pair switch drive and crossed-path selection.
  always_comb begin
    for (int p = 0; p < int'(G_NUM_PAIRS); p++) begin
      w_ctrl[p]  = 2'b00;
      w_cross[p] = 1'b0;
      case (mode_i[2*p +: 2])
        2'b01:   begin w_ctrl[p] = 2'b01; w_cross[p] = 1'b0; end
        2'b10:   begin w_ctrl[p] = 2'b10; w_cross[p] = 1'b1; end
        2'b11:   begin w_ctrl[p] = {r_swap_state, ~r_swap_state}; w_cross[p] = r_deswap_state; end
        default: begin w_ctrl[p] = 2'b00; w_cross[p] = 1'b0; end
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      w_s1_data[c] = w_cross[c/2] ? adc_data_i[(c^1)*DW +: DW] : adc_data_i[c*DW +: DW];
      w_s1_gain[c] = w_cross[c/2] ? gain_inv_i[c*GW +: GW] : gain_dir_i[c*GW +: GW];
      w_s1_off[c]  = (mode_i[2*(c/2) +: 2] == 2'b00);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      r_ctrl     <= '0;
      r_s1_valid <= 1'b0;
      for (int c = 0; c < int'(NCH); c++) begin
        r_s1_data[c] <= '0;
        r_s1_gain[c] <= '0;
        r_s1_off[c]  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < int'(G_NUM_PAIRS); p++) begin
        r_ctrl[2*p +: 2] <= w_ctrl[p];
      end
      r_s1_valid <= adc_valid_i;
      if (adc_valid_i) begin
        for (int c = 0; c < int'(NCH); c++) begin
          r_s1_data[c] <= w_s1_data[c];
          r_s1_gain[c] <= w_s1_gain[c];
          r_s1_off[c]  <= w_s1_off[c];
        end
      end
    end
  end

  // Signed sample times unsigned gain, rescale and saturate.
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_p = '0;
    w_sh = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      w_a  = {{(PW-DW){r_s1_data[c][DW-1]}}, r_s1_data[c]};
      w_b  = {{(PW-GW){1'b0}}, r_s1_gain[c]};
      w_p  = w_a * w_b;
      w_sh = w_p >>> G_GAIN_FRAC;
      if (r_s1_off[c])        w_res[c] = '0;
      else if (w_sh > SAT_MAX) w_res[c] = SAT_MAX[DW-1:0];
      else if (w_sh < SAT_MIN) w_res[c] = SAT_MIN[DW-1:0];
      else                     w_res[c] = w_sh[DW-1:0];
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int c = 0; c < int'(NCH); c++) begin
          r_data[c*DW +: DW] <= w_res[c];
        end
      end
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign ctrl_o       = r_ctrl;
  assign swap_sync_o  = r_swap_sync;

endmodule

// File: tb/tb_bpm_swap_deswap_n.sv
// Scoreboard bench for bpm_swap_deswap_n: directed samples, swap timing, saturation and reset.
module tb_bpm_swap_deswap_n;
  localparam logic [15:0] U = 16'd16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] adc_data;
  logic        adc_valid;
  logic [3:0]  mode;
  logic [15:0] div_f;
  logic [15:0] dly;
  logic [63:0] gain_dir;
  logic [63:0] gain_inv;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic [3:0]  ctrl_o;
  logic        swap_sync_o;
`ifdef BPM_SWAP_EXT_SYNC_EN
  logic        sync_trig;
`endif

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bpm_swap_deswap_n dut (
    .clk_sys_i    (clk),
    .rst_n_i      (rst_n),
    .adc_data_i   (adc_data),
    .adc_valid_i  (adc_valid),
    .mode_i       (mode),
    .swap_div_f_i (div_f),
    .deswap_dly_i (dly),
    .gain_dir_i   (gain_dir),
    .gain_inv_i   (gain_inv),
`ifdef BPM_SWAP_EXT_SYNC_EN
    .sync_trig_i  (sync_trig),
`endif
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .ctrl_o       (ctrl_o),
    .swap_sync_o  (swap_sync_o)
  );

  function automatic logic [63:0] pk(input logic [15:0] c0, input logic [15:0] c1,
                                     input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one sample right after a falling edge; output is due two rising edges later.
  task automatic send(input logic [63:0] d, input logic [63:0] e);
    adc_data  = d;
    adc_valid = 1'b1;
    q.push_back('{e, cyc + 2});
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (data_valid_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %0h with no pending sample", data_o);
      end else begin
        mon_e = q.pop_front();
        if (data_o !== mon_e.data || cyc != mon_e.due) begin
          errors++;
          $display("FAIL data_out: got %0h at cycle %0d expected %0h at cycle %0d",
                   data_o, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned last;
    int          bad_sync;
    int          bad_ctrl;
    bit          found;
    bit          s;
    rst_n     = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    mode      = 4'b0000;
    div_f     = '0;
    dly       = '0;
    gain_dir  = {U, U, U, U};
    gain_inv  = {U, U, U, U};
`ifdef BPM_SWAP_EXT_SYNC_EN
    sync_trig = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(data_valid_o), 64'd0);
    chk("reset_data", data_o, 64'd0);
    chk("reset_ctrl", 64'(ctrl_o), 64'd0);
    chk("reset_sync", 64'(swap_sync_o), 64'd0);

    rst_n = 1'b1;
    mode  = 4'b0101;
    @(negedge clk);
    chk("ctrl_direct", 64'(ctrl_o), 64'b0101);
    send(pk(16'h00ff, 16'hff00, 16'h00ff, 16'hff00), pk(16'h00ff, 16'hff00, 16'h00ff, 16'hff00));
    gain_dir = {U, U, U, 16'd49152};
    send(pk(16'd1, 16'd2, 16'd7, 16'hfff9), pk(16'd3, 16'd2, 16'd7, 16'hfff9));

    mode = 4'b1010;
    send(pk(16'd1, 16'd2, 16'd5, 16'hfffd), pk(16'd2, 16'd1, 16'hfffd, 16'd5));
    chk("ctrl_inverted", 64'(ctrl_o), 64'b1010);

    mode     = 4'b0101;
    gain_dir = {U, U, U, 16'd32768};
    send(pk(16'h7000, 16'h1234, 16'h0, 16'h0), pk(16'h7fff, 16'h1234, 16'h0, 16'h0));
    send(pk(16'h9000, 16'h0001, 16'h0, 16'h0), pk(16'h8000, 16'h0001, 16'h0, 16'h0));
    gain_dir = {U, U, U, 16'h2000};
    send(pk(16'hfffd, 16'h0, 16'h0, 16'h0), pk(16'hfffe, 16'h0, 16'h0, 16'h0));

    mode     = 4'b1010;
    gain_inv = {U, U, 16'd32768, U};
    send(pk(16'h5000, 16'h0010, 16'h0, 16'h0), pk(16'h0010, 16'h7fff, 16'h0, 16'h0));

    mode = 4'b0000;
    send(pk(16'h1234, 16'h5678, 16'h1111, 16'h2222), 64'd0);
    chk("ctrl_off", 64'(ctrl_o), 64'd0);
    repeat (3) @(negedge clk);
    gain_dir = {U, U, U, U};
    gain_inv = {U, U, U, U};

    // Switching: first toggle 10 cycles after enabling the divider.
    mode  = 4'b1111;
    dly   = 16'd3;
    div_f = 16'd9;
    last  = 0;
    for (int n = 1; n <= 3; n++) begin
      found = 1'b0;
      for (int t = 0; t < 30 && !found; t++) begin
        @(negedge clk);
        if (swap_sync_o) found = 1'b1;
      end
      chk("sync_seen", 64'(found), 64'd1);
      if (n > 1) chk("sync_period", 64'(cyc - last), 64'd10);
      last = cyc;
      chk("ctrl_before_toggle", 64'(ctrl_o), ((n - 1) % 2 == 1) ? 64'b1010 : 64'b0101);
      for (int i = 1; i <= 6; i++) begin
        s = (i <= 4) ? 1'((n - 1) % 2) : 1'(n % 2);
        send(pk(16'd1, 16'd2, 16'd1, 16'd2),
             s ? pk(16'd2, 16'd1, 16'd2, 16'd1) : pk(16'd1, 16'd2, 16'd1, 16'd2));
        if (i == 1) begin
          chk("ctrl_after_toggle", 64'(ctrl_o), (n % 2 == 1) ? 64'b1010 : 64'b0101);
          chk("sync_one_cycle", 64'(swap_sync_o), 64'd0);
        end
      end
    end

    // Count is 6 here; dropping the divisor to 3 toggles on the next edge.
    div_f = 16'd3;
    @(negedge clk);
    chk("lower_div_toggle", 64'(swap_sync_o), 64'd1);
    @(negedge clk);
    chk("ctrl_after_lower", 64'(ctrl_o), 64'b0101);

    div_f    = 16'd0;
    bad_sync = 0;
    bad_ctrl = 0;
    repeat (100) begin
      @(negedge clk);
      if (swap_sync_o) bad_sync++;
      if (ctrl_o !== 4'b0101) bad_ctrl++;
    end
    chk("div0_no_sync", 64'(bad_sync), 64'd0);
    chk("div0_ctrl_const", 64'(bad_ctrl), 64'd0);
    send(pk(16'd1, 16'd2, 16'd1, 16'd2), pk(16'd1, 16'd2, 16'd1, 16'd2));

`ifdef BPM_SWAP_EXT_SYNC_EN
    div_f = 16'd9;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      if (swap_sync_o) found = 1'b1;
    end
    chk("ext_first_sync", 64'(found), 64'd1);
    repeat (5) @(negedge clk);
    sync_trig = 1'b1;
    @(negedge clk);
    sync_trig = 1'b0;
    found = 1'b0;
    last  = 0;
    for (int t = 1; t <= 30 && !found; t++) begin
      @(negedge clk);
      if (t == 1) chk("ext_sync_state0", 64'(ctrl_o), 64'b0101);
      if (swap_sync_o) begin
        found = 1'b1;
        last  = t;
      end
    end
    chk("ext_sync_period", 64'(last), 64'd10);
    div_f = 16'd0;
    @(negedge clk);
`endif

    // Reset while two samples are in flight: neither may emerge.
    mode      = 4'b0101;
    adc_data  = pk(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    adc_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    adc_valid = 1'b0;
    chk("rst_mid_valid_a", 64'(data_valid_o), 64'd0);
    chk("rst_mid_ctrl", 64'(ctrl_o), 64'd0);
    @(negedge clk);
    chk("rst_mid_valid_b", 64'(data_valid_o), 64'd0);
    send(pk(16'h0abc, 16'h0def, 16'h0123, 16'h0456), pk(16'h0abc, 16'h0def, 16'h0123, 16'h0456));

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bpm_swap_deswap_n.md
Name: bpm_swap_deswap_n

Overview:
- Parametrised successor to the single-instance BPM swap block.
- Drives RF front-end crossbar control for G_NUM_PAIRS channel pairs from one swap-frequency divider.
- Uncrosses ("deswaps") the returning ADC stream after a programmable switch-settling delay, and applies per-path gain compensation with saturation.
- Sits between the ADC capture stage and the position-calculation chain; configuration comes from a separate register bank.

Parameters:
- G_NUM_PAIRS, 2: number of channel pairs (A/B, C/D, ...).
- G_DATA_WIDTH, 16: signed ADC sample width.
- G_GAIN_WIDTH, 16: unsigned gain width.
- G_GAIN_FRAC, 14: fractional bits of gain. Unity gain = 1<<G_GAIN_FRAC.
- G_DIV_WIDTH, 16: swap divider width.
- G_DLY_WIDTH, 16: deswap delay width.

Ports:
- clk_sys_i  in  1  system clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- adc_data_i  in  2*G_NUM_PAIRS*G_DATA_WIDTH  packed samples. Channel 2p = pair p side A, 2p+1 = side B.
- adc_valid_i  in  1  sample strobe.
- mode_i  in  2*G_NUM_PAIRS  per-pair mode: 00 off, 01 direct, 10 inverted, 11 switching.
- swap_div_f_i  in  G_DIV_WIDTH  half-period of swap, minus 1.
- deswap_dly_i  in  G_DLY_WIDTH  settling delay in clk cycles.
- gain_dir_i  in  2*G_NUM_PAIRS*G_GAIN_WIDTH  per-channel gain, uncrossed path.
- gain_inv_i  in  2*G_NUM_PAIRS*G_GAIN_WIDTH  per-channel gain, crossed path.
- data_o  out  2*G_NUM_PAIRS*G_DATA_WIDTH  deswapped, gain-compensated samples.
- data_valid_o  out  1  output strobe.
- ctrl_o  out  2*G_NUM_PAIRS  per pair {inv,dir} switch drive.
- swap_sync_o  out  1  one-cycle pulse on each swap_state toggle.

Behaviour:
- Reset (rst_n_i=0 at clk edge) clears:
  - divider counter, swap_state, deswap_state, delay counter;
  - data_o, data_valid_o, ctrl_o, swap_sync_o, and all pipeline registers.
- Reset mid-operation discards in-flight samples; no valid pulse is issued for them.
- Divider:
  - swap_div_f_i=0: counter held at 0, swap_state frozen.
  - Otherwise the counter increments each cycle. When counter >= swap_div_f_i it returns to 0, swap_state toggles, and swap_sync_o pulses the same cycle.
  - Full swap period = 2*(div+1) cycles.
  - Lowering div below the current count causes a toggle on the next cycle.
- Deswap delay:
  - On each toggle, load the delay counter with deswap_dly_i.
  - When the counter is 0, deswap_state <= swap_state. Latency from toggle = deswap_dly_i+1 cycles.
  - A toggle during countdown reloads the counter; deswap_state follows only the latest swap_state.
- ctrl_o per pair, registered, 1 cycle after mode or swap_state change:
  - off=00, direct=01, inverted=10;
  - switching = 01 when swap_state=0, 10 when swap_state=1.
- Crossed selection per pair:
  - direct: 0; inverted: 1; switching: deswap_state; off: don't care.
- Data path, 2-stage pipeline, latency 2 cycles, data_valid_o = adc_valid_i delayed 2:
  - Uncrossed: outA = inA*gdirA, outB = inB*gdirB.
  - Crossed: outA = inB*ginvA, outB = inA*ginvB.
  - Product: signed data × unsigned gain, full width, arithmetic shift right by G_GAIN_FRAC.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - Crossed selection is sampled in stage 1 together with the sample.
  - off: output 0 with valid still propagated.
- Gains and mode are sampled per sample in stage 1, so changes apply at a sample boundary only.

Optional Feature:
- Macro BPM_SWAP_EXT_SYNC_EN.
- When defined:
  - adds input sync_trig_i (1 bit);
  - a 1-cycle pulse forces counter=0, swap_state=0, deswap_state=0, delay counter=0 on the next edge;
  - no swap_sync_o pulse is generated for the forced reset;
  - sync_trig_i takes priority over a coincident divider toggle.
- When undefined: the port is absent and phase is free-running from reset.

Test Plan:
- Reset, then mode=01 all pairs, gains unity (16384), A=0x00ff, B=0xff00 -> data_o A=0x00ff, B=0xff00 after 2 cycles; ctrl_o pair=01.
- mode=10, gdirA=3*16384, ginvA=16384, A=1, B=2 -> outA=2, outB=1; ctrl_o=10.
- mode=11, div=9, dly=3 -> swap_sync_o every 10 cycles; ctrl_o alternates with period 20; deswap_state changes 4 cycles after each swap_sync_o.
- Gain 2.0 (32768), A=0x7000 -> outA saturates to 0x7fff; A=0x9000 -> 0x8000.
- div=0 while switching -> no swap_sync_o over 100 cycles, ctrl_o constant; rst_n_i low mid-stream -> data_valid_o 0 for the next 2 cycles.
- With BPM_SWAP_EXT_SYNC_EN, div=9: pulse sync_trig_i at count 5 -> next toggle exactly 10 cycles later, swap_state=0 afterwards.
